// File: rtl/dot_mem_reader.sv
// Streams N element pairs from two 1-cycle-latency memories in lockstep and
// multiply-accumulates them, then holds the unsigned dot product until it is accepted.
module dot_mem_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  rd_en_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_en_b,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = '0;

  logic [1:0]              state;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    issued;
  logic                    rd_en;
  logic                    pend;
  logic [ACC_WIDTH-1:0]    acc;
  logic [2*DATA_WIDTH-1:0] prod;

  assign busy    = (state != IDLE);
  assign rd_en_a = rd_en;
  assign rd_en_b = rd_en;
  assign result  = acc;

  assign prod = {{DATA_WIDTH{1'b0}}, rd_data_a} * {{DATA_WIDTH{1'b0}}, rd_data_b};

  // pend trails rd_en by one cycle, marking the cycle in which read data is on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      issued       <= '0;
      rd_en        <= 1'b0;
      rd_addr_a    <= '0;
      rd_addr_b    <= '0;
      pend         <= 1'b0;
      acc          <= '0;
      result_valid <= 1'b0;
    end else begin
      pend <= rd_en;
      if (pend) begin
        acc <= acc + {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod};
      end
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= length;
            acc   <= '0;
            if (length != LEN_ZERO) begin
              state     <= READ;
              rd_en     <= 1'b1;
              rd_addr_a <= base_a;
              rd_addr_b <= base_b;
              issued    <= LEN_ONE;
            end else begin
              state        <= DONE;
              result_valid <= 1'b1;
            end
          end
        end
        READ: begin
          if (issued == len_q) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr_a <= rd_addr_a + ADDR_ONE;
            rd_addr_b <= rd_addr_b + ADDR_ONE;
            issued    <= issued + LEN_ONE;
          end
        end
        DRAIN: begin
          state        <= DONE;
          result_valid <= 1'b1;
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_mem_reader.sv
// Directed bench for dot_mem_reader: behavioural 1-cycle-latency memories plus
// hand-computed expected results, latencies and read address sequences.
module tb_dot_mem_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  base_a, base_b;
  logic [4:0]  length;
  logic        busy;
  logic        rd_en_a, rd_en_b;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a = 8'h00;
  logic [7:0]  rd_data_b = 8'h00;
  logic [20:0] result;
  logic        result_valid;
  logic        result_ready;

  logic [7:0]  mem_a [16];
  logic [7:0]  mem_b [16];
  int          rd_count;
  int          rd_count_b;
  logic [3:0]  addr_log [$];
  int          checks = 0;
  int          errors = 0;

  dot_mem_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_a(base_a), .base_b(base_b),
    .length(length), .busy(busy),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories and a read monitor sampling the pre-edge values.
  always @(posedge clk) begin
    if (rd_en_a) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_count++;
      addr_log.push_back(rd_addr_a);
    end
    if (rd_en_b) begin
      rd_data_b <= mem_b[rd_addr_b];
      rd_count_b++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fillMem(input logic [7:0] a, input logic [7:0] b, input bit useIndex);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = useIndex ? 8'(i) : a;
      mem_b[i] = useIndex ? 8'(i) : b;
    end
  endtask

  // Launches one job and returns the cycle (start sampled in cycle 0) where result_valid rises.
  task automatic applyStimulus(input logic [3:0] ba, input logic [3:0] bb,
                               input logic [4:0] len, output int lat);
    @(negedge clk);
    rd_count   = 0;
    rd_count_b = 0;
    addr_log.delete();
    base_a = ba;
    base_b = bb;
    length = len;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("valid_seen", {31'd0, result_valid}, 32'd1);
  endtask

  task automatic completeHandshake(input string tag);
    @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_valid_low"}, {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int bad;
    logic [20:0] held;

    rst = 1'b1; start = 1'b0; base_a = '0; base_b = '0; length = '0; result_ready = 1'b0;
    rd_count = 0; rd_count_b = 0;
    fillMem(8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rd_en", {30'd0, rd_en_a, rd_en_b}, 32'd0);
    checkOutput("rst_addr", {24'd0, rd_addr_a, rd_addr_b}, 32'd0);
    checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_result", {11'd0, result}, 32'd0);
    rst = 1'b0;

    // Basic N=4 job: 33+34+35+36.
    fillMem(8'h01, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) mem_b[i] = 8'h21 + 8'(i);
    applyStimulus(4'd0, 4'd0, 5'd4, lat);
    checkOutput("t1_latency", lat, 32'd6);
    checkOutput("t1_result", {11'd0, result}, 32'd138);
    checkOutput("t1_reads_a", rd_count, 32'd4);
    checkOutput("t1_reads_b", rd_count_b, 32'd4);
    bad = 0;
    for (int i = 0; i < 4; i++) if (addr_log.size() != 4 || addr_log[i] != 4'(i)) bad++;
    checkOutput("t1_addrs", bad, 32'd0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    completeHandshake("t1");

    // Zero-length job completes immediately with no reads.
    applyStimulus(4'd3, 4'd5, 5'd0, lat);
    checkOutput("t2_latency", lat, 32'd1);
    checkOutput("t2_result", {11'd0, result}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t2_still_valid", {31'd0, result_valid}, 32'd1);
    checkOutput("t2_busy", {31'd0, busy}, 32'd1);
    checkOutput("t2_reads", rd_count, 32'd0);
    completeHandshake("t2");

    // Address wrap: 14,15,0,1.
    fillMem(8'h00, 8'h00, 1'b1);
    applyStimulus(4'd14, 4'd14, 5'd4, lat);
    checkOutput("t3_latency", lat, 32'd6);
    checkOutput("t3_result", {11'd0, result}, 32'd422);
    bad = 0;
    for (int i = 0; i < 4; i++) if (addr_log.size() != 4 || addr_log[i] != 4'(14 + i)) bad++;
    checkOutput("t3_addrs", bad, 32'd0);
    completeHandshake("t3");

    // Backpressure with start pulses that must be ignored.
    fillMem(8'h02, 8'h03, 1'b0);
    applyStimulus(4'd0, 4'd0, 5'd3, lat);
    checkOutput("t4_result", {11'd0, result}, 32'd18);
    held = result;
    rd_count = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1; length = 5'd5; base_a = 4'd1; base_b = 4'd2;
      @(negedge clk);
      start = 1'b0;
      checkOutput("t4_hold_valid", {31'd0, result_valid}, 32'd1);
      checkOutput("t4_hold_result", {11'd0, result}, {11'd0, held});
    end
    @(negedge clk);
    result_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    start = 1'b0;
    checkOutput("t4_idle", {31'd0, busy}, 32'd0);
    checkOutput("t4_valid_low", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    checkOutput("t4_no_restart", {31'd0, busy}, 32'd0);
    checkOutput("t4_no_reads", rd_count, 32'd0);

    // Maximum length, maximum data: no overflow, double wrap.
    fillMem(8'hFF, 8'hFF, 1'b0);
    applyStimulus(4'd0, 4'd0, 5'd31, lat);
    checkOutput("t5_latency", lat, 32'd33);
    checkOutput("t5_result", {11'd0, result}, 32'd2015775);
    checkOutput("t5_reads", rd_count, 32'd31);
    bad = 0;
    for (int i = 0; i < 31; i++) if (addr_log.size() != 31 || addr_log[i] != 4'(i % 16)) bad++;
    checkOutput("t5_addrs", bad, 32'd0);
    completeHandshake("t5");

    // Reset mid-READ aborts, then a fresh job runs cleanly.
    fillMem(8'h01, 8'h01, 1'b0);
    @(negedge clk);
    base_a = 4'd4; base_b = 4'd6; length = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_rd_en", {30'd0, rd_en_a, rd_en_b}, 32'd0);
    checkOutput("t6_addr", {24'd0, rd_addr_a, rd_addr_b}, 32'd0);
    checkOutput("t6_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("t6_result", {11'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fillMem(8'h03, 8'h05, 1'b0);
    applyStimulus(4'd0, 4'd0, 5'd2, lat);
    checkOutput("t6_latency", lat, 32'd4);
    checkOutput("t6_next_result", {11'd0, result}, 32'd30);
    completeHandshake("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
